nco_multiwave: RTL and testbench
================================

Name: nco_multiwave

Overview:
Parametrised phase-accumulator NCO producing a signed sine, square, triangle or sawtooth wave, selectable at run time. It uses a quarter-wave sine LUT that is generated at elaboration, and a per-instance phase offset for quadrature or multi-phase sets. The output stage is pipelined with a valid flag and a cycle-wrap marker. It drops into the waveform-generator datapath wherever a single-wave 8-bit NCO is used today.

Parameters:
PHASE_W, 32, accumulator / control word width; must be >= ADDR_W and >= OUT_W+1
OUT_W, 8, signed output amplitude width; must be >= 4
ADDR_W, 8, phase bits used to address the sine; must be >= 3; quarter LUT holds Q+1 entries, Q = 2^(ADDR_W-2)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
enable  in  1  accumulator advances when high
control  in  PHASE_W  frequency control word; f = clk * control / 2^PHASE_W
control_load  in  1  one-cycle strobe; capture control
phase_offset  in  PHASE_W  added to phase before waveform mapping
wave_sel  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
sync  in  1  phase restart strobe
amplitude  out  OUT_W  signed sample
valid  out  1  amplitude holds a sample from an enabled step
wrap  out  1  one-cycle pulse on the first sample of a new wave cycle

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset. Reset clears phase, active control word, pending control word, pipeline, amplitude (0), valid (0) and wrap (0).
- Control capture: control_load high on edge N puts control into the active word at edge N; the first step using it is edge N+1.
- Phase priority, per edge: reset > sync (phase <= 0, carry flag 0) > enable (phase <= phase + active, modulo 2^PHASE_W; carry flag = carry-out) > hold.
- Pipeline stage 1: p = phase + phase_offset (modulo); register p, wave_sel, enable as v1, carry as c1.
- Pipeline stage 2: map p to the sample. Register amplitude, valid <= v1, wrap <= c1 & v1.
- Latency: phase register contents appear on amplitude 2 edges later. Pipeline registers advance every cycle regardless of enable.
- Sine: a = p[PHASE_W-1 -: ADDR_W], quadrant = a[top 2], k = lower ADDR_W-2 bits. LUT[i] = round(A * sin(pi/2 * i/Q)), A = 2^(OUT_W-1)-1. The quadrants map as follows:
  - q0: +LUT[k]
  - q1: +LUT[Q-k]
  - q2: -LUT[k]
  - q3: -LUT[Q-k]
- Sine range: the output never reaches -2^(OUT_W-1).
- Square: +A when p msb = 0, else -A.
- Sawtooth: s = p[PHASE_W-1 -: OUT_W] with its msb inverted. It ramps -2^(OUT_W-1) to +A.
- Triangle: u = p[PHASE_W-1 -: OUT_W+1], v = u[OUT_W-1:0], inverted bitwise when u msb = 1. Output is v with its msb inverted.
- wave_sel change: takes effect with the sample computed from that cycle's phase. There is no glitch filtering.
- Simultaneous sync and control_load: both take effect on the same edge.
- Reset mid-operation: all state clears on that edge. valid stays low until enable is held for 2 further edges.

Optional Feature:
SYNC_UPDATE_EN
- With the macro: control_load writes the pending word. Pending transfers to active on the first enabled step that produces carry-out, or immediately on sync. This gives phase-continuous, cycle-aligned frequency changes. A second load before transfer overwrites pending.
- Without the macro: control_load writes the active word directly, as described in Behaviour, and no pending register exists.

Test Plan:
- Sine cycle: defaults, reset then control=0x01000000, enable=1, wave_sel=0 -> valid-qualified samples 0x00,0x03,0x06,0x09... Sample 64 = 0x7F, sample 128 = 0x00, sample 192 = 0x81, sample 255 = 0xFD, then wrap=1 with sample 256 = 0x00.
- Square wave: control=0x40000000, wave_sel=1 -> 0x7F,0x7F,0x81,0x81 repeating; wrap on every 4th sample.
- Sawtooth and triangle: control=0x01000000. Sawtooth gives 0x80,0x81,0x82,... to 0x7F. Triangle gives 0x80,0x82,0x84,... peaking at 0x7E/0x7F near sample 128, then descending.
- Phase offset: phase_offset=0x40000000, sine, control=0x01000000 -> first valid sample 0x7F (cosine); second instance at offset 0 gives 0x00 on the same cycle.
- Sync and reset: sync mid-run -> amplitude 0x00 exactly 2 edges later, sequence restarts. reset mid-run -> amplitude=0, valid=0 next edge, and valid returns 2 edges after enable.
- SYNC_UPDATE_EN: load 0x02000000 mid-cycle while 0x01000000 is active -> step stays 0x01000000 until the carry; the sample after wrap uses the new step. Without the macro, the step changes on the edge after the load.

Source files
------------

// File: rtl/nco_multiwave_if.sv
// Control and sample bundle for nco_multiwave: the master drives frequency,
// phase and waveform controls; the slave returns the pipelined sample.
interface nco_multiwave_if #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 8
);
    logic               enable;
    logic [PHASE_W-1:0] control;
    logic               control_load;
    logic [PHASE_W-1:0] phase_offset;
    logic [1:0]         wave_sel;
    logic               sync;
    logic [OUT_W-1:0]   amplitude;
    logic               valid;
    logic               wrap;

    modport master (
        output enable, control, control_load, phase_offset, wave_sel, sync,
        input  amplitude, valid, wrap
    );

    modport slave (
        input  enable, control, control_load, phase_offset, wave_sel, sync,
        output amplitude, valid, wrap
    );
endinterface

// File: rtl/nco_multiwave.sv
// Phase-accumulator NCO with sine/square/triangle/sawtooth output and a 2-stage output pipeline.
// Define SYNC_UPDATE_EN to defer control-word changes to the next cycle wrap (or sync).
module nco_multiwave #(
    parameter int PHASE_W = 32,
    parameter int OUT_W   = 8,
    parameter int ADDR_W  = 8
) (
    input  logic           clk,
    input  logic           reset,
    nco_multiwave_if.slave bus
);
    localparam int  Q     = 2 ** (ADDR_W - 2);
    localparam real PI    = 3.14159265358979323846;
    localparam real AMP_R = real'((2 ** (OUT_W - 1)) - 1);

    localparam logic [OUT_W-1:0]  AMP     = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0]  NEG_AMP = {1'b1, {(OUT_W-2){1'b0}}, 1'b1};
    localparam logic [ADDR_W-2:0] Q_IDX   = (ADDR_W-1)'(Q);

    // Quarter-wave entries are all non-negative, so rounding is a plain +0.5 truncate.
    function automatic logic [OUT_W-1:0] sine_entry(input int i);
        return OUT_W'($rtoi(AMP_R * $sin(PI / 2.0 * real'(i) / real'(Q)) + 0.5));
    endfunction

    logic [OUT_W-1:0] lut [Q+1];

    for (genvar i = 0; i <= Q; i++) begin : g_lut
        assign lut[i] = sine_entry(i);
    end

    logic [PHASE_W-1:0] phase;
    logic [PHASE_W-1:0] active;
    logic               carry;
    logic [PHASE_W:0]   sum;

    logic [PHASE_W-1:0] p1;
    logic [1:0]         sel1;
    logic               v1;
    logic               c1;

    logic [OUT_W-1:0]   amp_q;
    logic               valid_q;
    logic               wrap_q;

`ifdef SYNC_UPDATE_EN
    logic [PHASE_W-1:0] pending;
    logic               pend_vld;
`endif

    assign sum = {1'b0, phase} + {1'b0, active};

    always_ff @(posedge clk) begin
        if (reset) begin
            phase   <= '0;
            active  <= '0;
            carry   <= 1'b0;
            p1      <= '0;
            sel1    <= '0;
            v1      <= 1'b0;
            c1      <= 1'b0;
            amp_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
`ifdef SYNC_UPDATE_EN
            pending  <= '0;
            pend_vld <= 1'b0;
`endif
        end else begin
            if (bus.sync) begin
                phase <= '0;
                carry <= 1'b0;
            end else if (bus.enable) begin
                phase <= sum[PHASE_W-1:0];
                carry <= sum[PHASE_W];
            end

`ifdef SYNC_UPDATE_EN
            // A load coinciding with the transfer point goes straight to the active word.
            if (bus.sync || (bus.enable && sum[PHASE_W])) begin
                if (bus.control_load) begin
                    active <= bus.control;
                end else if (pend_vld) begin
                    active <= pending;
                end
                pend_vld <= 1'b0;
            end else if (bus.control_load) begin
                pending  <= bus.control;
                pend_vld <= 1'b1;
            end
`else
            if (bus.control_load) begin
                active <= bus.control;
            end
`endif

            p1      <= phase + bus.phase_offset;
            sel1    <= bus.wave_sel;
            v1      <= bus.enable;
            c1      <= carry;

            amp_q   <= sample;
            valid_q <= v1;
            wrap_q  <= c1 & v1;
        end
    end

    logic [ADDR_W-1:0] sine_addr;
    logic [1:0]        quad;
    logic [ADDR_W-2:0] lut_idx;
    logic [OUT_W-1:0]  sine_mag;
    logic [OUT_W:0]    tri_u;
    logic [OUT_W-1:0]  tri_v;
    logic [OUT_W-1:0]  sample;

    always_comb begin
        sine_addr = p1[PHASE_W-1 -: ADDR_W];
        quad      = sine_addr[ADDR_W-1 -: 2];
        lut_idx   = {1'b0, sine_addr[ADDR_W-3:0]};
        if (quad[0]) begin
            lut_idx = Q_IDX - {1'b0, sine_addr[ADDR_W-3:0]};
        end
        sine_mag  = lut[lut_idx];
        tri_u     = p1[PHASE_W-1 -: OUT_W+1];
        tri_v     = tri_u[OUT_W] ? ~tri_u[OUT_W-1:0] : tri_u[OUT_W-1:0];
        sample    = '0;
        case (sel1)
            2'd0:    sample = quad[1] ? (~sine_mag + 1'b1) : sine_mag;
            2'd1:    sample = p1[PHASE_W-1] ? NEG_AMP : AMP;
            2'd2:    sample = {~tri_v[OUT_W-1], tri_v[OUT_W-2:0]};
            default: sample = {~p1[PHASE_W-1], p1[PHASE_W-2 -: OUT_W-1]};
        endcase
    end

    // Only the top phase bits shape the waveform; the rest carry fractional precision.
    logic unused_p1_low;
    assign unused_p1_low = ^p1;

    assign bus.amplitude = amp_q;
    assign bus.valid     = valid_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_nco_multiwave.sv
// Scoreboard bench for nco_multiwave: a phase/waveform model predicts each
// enabled sample; a negedge monitor pops and compares whenever valid is high.
module tb_nco_multiwave;
    localparam int  PHASE_W = 32;
    localparam int  OUT_W   = 8;
    localparam int  ADDR_W  = 8;
    localparam real PI      = 3.14159265358979323846;

    typedef struct {
        logic [7:0] amp;
        logic       wrap;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];

    bit [31:0] ctl = '0;
    bit [31:0] off = '0;
    bit [1:0]  sel = '0;

    bit [31:0] m_phase  = '0;
    bit [31:0] m_active = '0;
    bit        m_carry  = 1'b0;
    bit [31:0] m_pend   = '0;
    bit        m_pvld   = 1'b0;

    nco_multiwave_if #(.PHASE_W(PHASE_W), .OUT_W(OUT_W)) bus ();

    nco_multiwave #(.PHASE_W(PHASE_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Waveform as a function of full-cycle phase, from the waveform definitions.
    function automatic int wave_model(input bit [31:0] p, input bit [1:0] ws);
        int  a;
        int  t;
        real s;
        case (ws)
            2'd0: begin
                a = int'(p >> 24);
                s = 127.0 * $sin(2.0 * PI * real'(a) / 256.0);
                return (s >= 0.0) ? $rtoi(s + 0.5) : -$rtoi(-s + 0.5);
            end
            2'd1: return p[31] ? -127 : 127;
            2'd2: begin
                t = int'(p >> 23);
                return (t < 256) ? (t - 128) : (383 - t);
            end
            default: return int'(p >> 24) - 128;
        endcase
    endfunction

    task automatic model_update(input bit rst, input bit en, input bit ld, input bit sy);
        bit [32:0] s;
        bit        co;
        if (rst) begin
            m_phase  = '0;
            m_active = '0;
            m_carry  = 1'b0;
            m_pend   = '0;
            m_pvld   = 1'b0;
        end else begin
            s  = {1'b0, m_phase} + {1'b0, m_active};
            co = 1'b0;
            if (sy) begin
                m_phase = '0;
                m_carry = 1'b0;
            end else if (en) begin
                m_phase = s[31:0];
                m_carry = s[32];
                co      = s[32];
            end
`ifdef SYNC_UPDATE_EN
            if (sy || co) begin
                if (ld) m_active = ctl;
                else if (m_pvld) m_active = m_pend;
                m_pvld = 1'b0;
            end else if (ld) begin
                m_pend = ctl;
                m_pvld = 1'b1;
            end
`else
            if (ld) m_active = ctl;
`endif
        end
    endtask

    // Apply one edge's worth of inputs; predicted sample is queued before the edge.
    task automatic step(input bit rst, input bit en, input bit ld, input bit sy);
        exp_t e;
        reset            = rst;
        bus.enable       = en;
        bus.control_load = ld;
        bus.control      = ctl;
        bus.phase_offset = off;
        bus.wave_sel     = sel;
        bus.sync         = sy;
        if (!rst && en) begin
            e.amp  = 8'(wave_model(m_phase + off, sel));
            e.wrap = m_carry;
            sbq.push_back(e);
        end
        model_update(rst, en, ld, sy);
        @(posedge clk);
        #1;
        if (rst) sbq.delete();
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (bus.valid === 1'b1) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample: got amp 0x%0h wrap %0b expected no sample", bus.amplitude, bus.wrap);
            end else begin
                e = sbq.pop_front();
                if (bus.amplitude !== e.amp || bus.wrap !== e.wrap) begin
                    errors++;
                    $display("FAIL sample t=%0t: got amp 0x%0h wrap %0b expected amp 0x%0h wrap %0b", $time, bus.amplitude, bus.wrap, e.amp, e.wrap);
                end
            end
        end
    end

    initial begin
        bit ld;
        reset            = 1'b1;
        bus.enable       = 1'b0;
        bus.control_load = 1'b0;
        bus.control      = '0;
        bus.phase_offset = '0;
        bus.wave_sel     = '0;
        bus.sync         = 1'b0;

        repeat (3) step(1, 0, 0, 0);
        check("reset_amplitude", 32'(bus.amplitude), 32'h0);
        check("reset_valid", 32'(bus.valid), 32'h0);
        check("reset_wrap", 32'(bus.wrap), 32'h0);

        // Full sine cycle plus the wrap into the next one
        ctl = 32'h0100_0000;
        sel = 2'd0;
        step(0, 0, 1, 0);
        repeat (262) step(0, 1, 0, 0);

        // Sync restarts the sequence: zero-phase sine two edges later
        step(0, 1, 0, 1);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("sync_restart_amp", 32'(bus.amplitude), 32'h0);
        check("sync_restart_valid", 32'(bus.valid), 32'h1);
        repeat (10) step(0, 1, 0, 0);

        // Square at a quarter-cycle step
        ctl = 32'h4000_0000;
        sel = 2'd1;
        step(0, 1, 1, 1);
        repeat (16) step(0, 1, 0, 0);

        // Sawtooth and triangle over a full cycle each
        ctl = 32'h0100_0000;
        sel = 2'd3;
        step(0, 1, 1, 1);
        repeat (260) step(0, 1, 0, 0);
        sel = 2'd2;
        step(0, 1, 0, 1);
        repeat (260) step(0, 1, 0, 0);

        // Quarter-cycle offset turns sine into cosine
        off = 32'h4000_0000;
        sel = 2'd0;
        step(0, 1, 0, 1);
        repeat (12) step(0, 1, 0, 0);
        off = '0;

        // Reset mid-run clears the output and valid returns two enabled edges later
        step(1, 1, 0, 0);
        check("midrst_amplitude", 32'(bus.amplitude), 32'h0);
        check("midrst_valid", 32'(bus.valid), 32'h0);
        check("midrst_wrap", 32'(bus.wrap), 32'h0);
        step(0, 1, 1, 0);
        check("midrst_valid_1edge", 32'(bus.valid), 32'h0);
        step(0, 1, 0, 0);
        check("midrst_valid_2edge", 32'(bus.valid), 32'h1);

        // Step change mid-cycle
        repeat (40) step(0, 1, 0, 0);
        ctl = 32'h0200_0000;
        step(0, 1, 1, 0);
        repeat (300) step(0, 1, 0, 0);

        for (int i = 0; i < 1500; i++) begin
            ld = ($urandom_range(0, 19) == 0);
            if (ld) ctl = $urandom >> $urandom_range(0, 12);
            if ($urandom_range(0, 19) == 0) sel = 2'($urandom);
            if ($urandom_range(0, 29) == 0) off = $urandom;
            step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, ld, $urandom_range(0, 39) == 0);
        end

        repeat (3) step(0, 0, 0, 0);
        check("drain_valid", 32'(bus.valid), 32'h0);
        check("scoreboard_empty", 32'(sbq.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
